// File: rtl/ddr_test_ctrl.sv
// DDR test controller: sequential write/read sweeps and an LFSR-driven random read run on a MIG app port.
// Optional macro DDR_TEST_CMP_EN enables the read-data compare and err_cnt; undefined, err_cnt is 0.
module ddr_test_ctrl #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int ADDR_STEP    = 8,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_BEATS = 129,
  parameter int RAND_BITS    = 7,
  parameter int RAND_BEATS   = 64,
  parameter int MAX_OUTST    = 16,
  parameter int ERR_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [7:0]          cmd_data,
  input  logic                init_calib_complete,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  input  logic                app_rd_data_valid,
  input  logic [DATA_W-1:0]   app_rd_data,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                busy,
  output logic                done,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RND = 2'd3} state_t;

  localparam int LANES = DATA_W / 32;
  localparam int MAX_BEATS = (REGION_BEATS > RAND_BEATS) ? REGION_BEATS : RAND_BEATS;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    for (int i = 0; i < LANES; i++) pattern[i*32 +: 32] = a32 ^ (32'hA5A5_0000 + 32'(i));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr(input logic [15:0] l);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(l[RAND_BITS-1:0]) * ADDR_W'(ADDR_STEP);
  endfunction

  state_t              state_reg, state_next;
  logic                app_en_reg, app_en_next;
  logic [2:0]          app_cmd_reg, app_cmd_next;
  logic [ADDR_W-1:0]   app_addr_reg, app_addr_next;
  logic                wren_reg, wren_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                done_reg, done_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0]    ret_reg, ret_next;
  logic [OUT_W-1:0]    outst_reg, outst_next;
  logic [15:0]         lfsr_reg, lfsr_next;
  logic                start_read;
  logic                cmd_acc, data_acc, ret_fire;
  logic [CNT_W-1:0]    total;

  // Handshakes only count while calibrated, so a calibration loss freezes issue.
  assign cmd_acc  = app_en_reg && app_rdy && init_calib_complete;
  assign data_acc = wren_reg && app_wdf_rdy && init_calib_complete;
  assign ret_fire = app_rd_data_valid && (state_reg == RD || state_reg == RND);
  assign total    = (state_reg == RND) ? CNT_W'(RAND_BEATS) : CNT_W'(REGION_BEATS);

  always_comb begin
    state_next    = state_reg;
    app_en_next   = app_en_reg;
    app_cmd_next  = app_cmd_reg;
    app_addr_next = app_addr_reg;
    wren_next     = wren_reg;
    wdata_next    = wdata_reg;
    done_next     = 1'b0;
    cnt_next      = cnt_reg;
    ret_next      = ret_reg;
    outst_next    = outst_reg;
    lfsr_next     = lfsr_reg;
    start_read    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid && init_calib_complete) begin
          case (cmd_data)
            8'h01: begin
              state_next    = WR;
              app_en_next   = 1'b1;
              app_cmd_next  = CMD_WR;
              app_addr_next = ADDR_W'(BASE_ADDR);
              wren_next     = 1'b1;
              wdata_next    = pattern(ADDR_W'(BASE_ADDR));
              cnt_next      = '0;
            end
            8'h02, 8'h03: begin
              state_next    = (cmd_data == 8'h02) ? RD : RND;
              app_en_next   = 1'b1;
              app_cmd_next  = CMD_RD;
              app_addr_next = (cmd_data == 8'h02) ? ADDR_W'(BASE_ADDR) : rnd_addr(LFSR_SEED);
              cnt_next      = '0;
              ret_next      = '0;
              outst_next    = '0;
              lfsr_next     = LFSR_SEED;
              start_read    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      WR: begin
        if (init_calib_complete) begin
          if (cmd_acc) app_en_next = 1'b0;
          if (data_acc) wren_next = 1'b0;
          // Beat retires once both halves are in; the next beat goes out on the following cycle.
          if ((!app_en_reg || cmd_acc) && (!wren_reg || data_acc)) begin
            if (cnt_reg == CNT_W'(REGION_BEATS - 1)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              cnt_next      = cnt_reg + 1'b1;
              app_addr_next = app_addr_reg + ADDR_W'(ADDR_STEP);
              wdata_next    = pattern(app_addr_reg + ADDR_W'(ADDR_STEP));
              app_en_next   = 1'b1;
              wren_next     = 1'b1;
            end
          end
        end
      end
      RD, RND: begin
        if (cmd_acc) begin
          cnt_next = cnt_reg + 1'b1;
          if (state_reg == RND) begin
            lfsr_next     = lfsr_step(lfsr_reg);
            app_addr_next = rnd_addr(lfsr_step(lfsr_reg));
          end else begin
            app_addr_next = app_addr_reg + ADDR_W'(ADDR_STEP);
          end
        end
        if (cmd_acc && !ret_fire) outst_next = outst_reg + 1'b1;
        else if (!cmd_acc && ret_fire && outst_reg != '0) outst_next = outst_reg - 1'b1;
        if (init_calib_complete && (!app_en_reg || cmd_acc))
          app_en_next = (cnt_next < total) && (outst_next < OUT_W'(MAX_OUTST));
        if (ret_fire) begin
          ret_next = ret_reg + 1'b1;
          if (ret_reg == total - 1'b1) begin
            state_next  = IDLE;
            done_next   = 1'b1;
            app_en_next = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      app_en_reg   <= 1'b0;
      app_cmd_reg  <= CMD_WR;
      app_addr_reg <= '0;
      wren_reg     <= 1'b0;
      wdata_reg    <= '0;
      done_reg     <= 1'b0;
      cnt_reg      <= '0;
      ret_reg      <= '0;
      outst_reg    <= '0;
      lfsr_reg     <= LFSR_SEED;
    end else begin
      state_reg    <= state_next;
      app_en_reg   <= app_en_next;
      app_cmd_reg  <= app_cmd_next;
      app_addr_reg <= app_addr_next;
      wren_reg     <= wren_next;
      wdata_reg    <= wdata_next;
      done_reg     <= done_next;
      cnt_reg      <= cnt_next;
      ret_reg      <= ret_next;
      outst_reg    <= outst_next;
      lfsr_reg     <= lfsr_next;
    end
  end

  assign app_en       = app_en_reg;
  assign app_cmd      = app_cmd_reg;
  assign app_addr     = app_addr_reg;
  assign app_wdf_wren = wren_reg;
  assign app_wdf_end  = wren_reg;
  assign app_wdf_data = wdata_reg;
  assign app_wdf_mask = '0;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign state        = state_reg;

`ifdef DDR_TEST_CMP_EN
  // Return side replays the issue-side address sequence; returns arrive in order.
  logic [ERR_W-1:0]  err_reg;
  logic [15:0]       rlfsr_reg;
  logic [ADDR_W-1:0] exp_addr_reg;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [LANES-1:0]  lane_bad;

  assign exp_addr = (state_reg == RND) ? rnd_addr(rlfsr_reg) : exp_addr_reg;
  assign exp_data = pattern(exp_addr);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bad[gi] = (app_rd_data[gi*32 +: 32] != exp_data[gi*32 +: 32]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg      <= '0;
      rlfsr_reg    <= LFSR_SEED;
      exp_addr_reg <= '0;
    end else if (start_read) begin
      err_reg      <= '0;
      rlfsr_reg    <= LFSR_SEED;
      exp_addr_reg <= ADDR_W'(BASE_ADDR);
    end else if (ret_fire) begin
      if (state_reg == RND) rlfsr_reg <= lfsr_step(rlfsr_reg);
      else exp_addr_reg <= exp_addr_reg + ADDR_W'(ADDR_STEP);
      if ((|lane_bad) && (err_reg != {ERR_W{1'b1}})) err_reg <= err_reg + 1'b1;
    end
  end

  assign err_cnt = err_reg;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^{app_rd_data, start_read};
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_test_ctrl.sv
// Self-checking bench for ddr_test_ctrl: MIG model with configurable ready/latency/corruption
// and a reference model of the write/read address and data sequences.
module tb_ddr_test_ctrl;
  localparam int ADDR_W = 28, DATA_W = 128, ADDR_STEP = 8, BASE_ADDR = 0;
  localparam int REGION_BEATS = 129, RAND_BITS = 7, RAND_BEATS = 64, MAX_OUTST = 16, ERR_W = 16;
  localparam int LAT = 20;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic init_calib_complete = 1'b1, app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0;
  logic [DATA_W-1:0] app_rd_data = '0;
  logic app_en, app_wdf_wren, app_wdf_end, busy, done;
  logic [2:0] app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0] state;

  ddr_test_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(ADDR_STEP), .BASE_ADDR(BASE_ADDR),
    .REGION_BEATS(REGION_BEATS), .RAND_BITS(RAND_BITS), .RAND_BEATS(RAND_BEATS),
    .MAX_OUTST(MAX_OUTST), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .init_calib_complete(init_calib_complete), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .busy(busy), .done(done), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [ADDR_W-1:0] addr;} rd_t;

  int checks = 0, passed = 0;
  int cyc = 0;
  bit rdy_rand = 0, corrupt_all = 0, reads_active = 0;
  int stall_left = 0, corrupt_a = -1, corrupt_b = -1, ret_idx = 0;
  logic [31:0] stall_addr = '1;
  rd_t rq[$];
  logic [ADDR_W-1:0] wcmd_addr[$], rcmd_addr[$];
  int wcmd_cyc[$], wdat_cyc[$];
  logic [DATA_W-1:0] wdat[$];
  int rets = 0, outst = 0, max_outst = 0, done_cnt = 0, done_bad = 0, end_viol = 0, en_stall_cycles = 0;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = 32'(a) ^ (32'hA5A5_0000 + 32'(i));
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] seq_addr(input int k);
    return ADDR_W'(BASE_ADDR + k * ADDR_STEP);
  endfunction

  // MIG model: inputs change 1 time unit after the rising edge.
  always @(posedge clk) begin
    logic [DATA_W-1:0] d;
    #1;
    cyc++;
    app_rdy = init_calib_complete && (!rdy_rand || ($urandom % 4 != 0));
    if (stall_left > 0 && app_wdf_wren && ((app_wdf_data[31:0] ^ 32'hA5A5_0000) == stall_addr)) begin
      app_wdf_rdy = 1'b0;
      stall_left--;
    end else begin
      app_wdf_rdy = init_calib_complete && (!rdy_rand || ($urandom % 4 != 0));
    end
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      d = pat(rq[0].addr);
      if (corrupt_all || ret_idx == corrupt_a || ret_idx == corrupt_b) d[0] = ~d[0];
      ret_idx++;
      app_rd_data = d;
      app_rd_data_valid = 1'b1;
      void'(rq.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (app_en && app_rdy && init_calib_complete) begin
      if (app_cmd == 3'b000) begin
        wcmd_addr.push_back(app_addr);
        wcmd_cyc.push_back(cyc);
      end else begin
        rcmd_addr.push_back(app_addr);
        rq.push_back('{due: cyc + LAT, addr: app_addr});
        if (reads_active) outst++;
      end
    end
    if (app_wdf_wren && app_wdf_rdy && init_calib_complete) begin
      wdat.push_back(app_wdf_data);
      wdat_cyc.push_back(cyc);
    end
    if (reads_active && app_rd_data_valid) begin
      rets++;
      outst--;
    end
    if (outst > max_outst) max_outst = outst;
    if (app_wdf_end !== app_wdf_wren || app_wdf_mask !== '0) end_viol++;
    if (app_en && app_cmd == 3'b000 && 32'(app_addr) == stall_addr) en_stall_cycles++;
    if (done) begin
      done_cnt++;
      if (state !== 2'd0) done_bad++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    $display("cmd 0x%02h at cycle %0d", b, cyc);
    cmd_valid = 1'b1;
    cmd_data = b;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wcmd_addr.delete(); rcmd_addr.delete(); wcmd_cyc.delete(); wdat_cyc.delete(); wdat.delete();
    rets = 0; outst = 0; max_outst = 0; done_bad = 0; end_viol = 0; en_stall_cycles = 0; ret_idx = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt > start) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
    checks++; if ({app_en, app_wdf_wren, app_wdf_end, done, busy} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {app_en, app_wdf_wren, app_wdf_end, done, busy}); else passed++;
    checks++; if (err_cnt !== '0 || app_cmd !== 3'b000) $display("FAIL reset_err_cmd: got err=%0d cmd=%0d expected 0/0", err_cnt, app_cmd); else passed++;
    checks++; if (app_addr !== '0 || app_wdf_data !== '0) $display("FAIL reset_addr_data: got addr=%0h expected 0", app_addr); else passed++;
  endtask

  task automatic test_write(input bit rand_rdy, input int stall_beat);
    bit ok;
    int bad_a, bad_d, viol, prev;
    rdy_rand = rand_rdy;
    clear_logs();
    stall_addr = (stall_beat >= 0) ? 32'(seq_addr(stall_beat)) : '1;
    stall_left = (stall_beat >= 0) ? 3 : 0;
    send_cmd(8'h01);
    wait_done(3000, ok);
    checks++; if (!ok) $display("FAIL wr_done: got no done expected done pulse"); else passed++;
    checks++; if (wcmd_addr.size() != REGION_BEATS || wdat.size() != REGION_BEATS)
      $display("FAIL wr_count: got cmd=%0d data=%0d expected %0d", wcmd_addr.size(), wdat.size(), REGION_BEATS); else passed++;
    bad_a = 0; bad_d = 0; viol = 0;
    for (int k = 0; k < wcmd_addr.size(); k++) if (wcmd_addr[k] !== seq_addr(k)) bad_a++;
    for (int k = 0; k < wdat.size(); k++) if (wdat[k] !== pat(seq_addr(k))) bad_d++;
    for (int k = 1; k < wcmd_cyc.size() && k < wdat_cyc.size(); k++) begin
      prev = (wcmd_cyc[k-1] > wdat_cyc[k-1]) ? wcmd_cyc[k-1] : wdat_cyc[k-1];
      if (wcmd_cyc[k] <= prev || wdat_cyc[k] <= prev) viol++;
    end
    checks++; if (bad_a != 0) $display("FAIL wr_addr: got %0d wrong addresses expected 0", bad_a); else passed++;
    checks++; if (bad_d != 0) $display("FAIL wr_data: got %0d wrong data beats expected 0", bad_d); else passed++;
    checks++; if (viol != 0) $display("FAIL wr_order: got %0d overlapping beats expected 0", viol); else passed++;
    checks++; if (state !== 2'd0 || done_bad != 0 || end_viol != 0)
      $display("FAIL wr_end: got state=%0d done_bad=%0d end_viol=%0d expected 0/0/0", state, done_bad, end_viol); else passed++;
    if (!rand_rdy && stall_beat < 0 && wdat.size() > 1) begin
      checks++; if (wdat[1][31:0] !== 32'hA5A5_0008) $display("FAIL wr_lane0_beat1: got %08h expected a5a50008", wdat[1][31:0]); else passed++;
      checks++; if (wcmd_cyc[REGION_BEATS-1] - wcmd_cyc[0] != REGION_BEATS - 1)
        $display("FAIL wr_back_to_back: got span %0d expected %0d", wcmd_cyc[REGION_BEATS-1] - wcmd_cyc[0], REGION_BEATS - 1); else passed++;
    end
    if (stall_beat >= 0 && wdat_cyc.size() > stall_beat + 1) begin
      checks++; if (wdat_cyc[stall_beat] - wcmd_cyc[stall_beat] != 3)
        $display("FAIL stall_data_lag: got %0d expected 3", wdat_cyc[stall_beat] - wcmd_cyc[stall_beat]); else passed++;
      checks++; if (wcmd_cyc[stall_beat+1] != wdat_cyc[stall_beat] + 1)
        $display("FAIL stall_next_beat: got cycle %0d expected %0d", wcmd_cyc[stall_beat+1], wdat_cyc[stall_beat] + 1); else passed++;
      checks++; if (en_stall_cycles != 1) $display("FAIL stall_en_drop: got %0d app_en cycles expected 1", en_stall_cycles); else passed++;
    end
    stall_addr = '1;
    rdy_rand = 0;
  endtask

  task automatic test_calib();
    bit ok;
    logic [ADDR_W-1:0] a_hold;
    int n_hold, bad_a;
    init_calib_complete = 1'b0;
    send_cmd(8'h01);
    tick(5);
    checks++; if (state !== 2'd0) $display("FAIL uncal_cmd: got state %0d expected 0", state); else passed++;
    init_calib_complete = 1'b1;
    tick(1);
    clear_logs();
    send_cmd(8'h01);
    tick(20);
    init_calib_complete = 1'b0;
    tick(1);
    a_hold = app_addr;
    n_hold = wcmd_addr.size();
    tick(5);
    checks++; if (app_addr !== a_hold || wcmd_addr.size() != n_hold || app_en !== 1'b1 || state !== 2'd1)
      $display("FAIL calib_hold: got addr=%0h beats=%0d en=%b expected addr=%0h beats=%0d en=1", app_addr, wcmd_addr.size(), app_en, a_hold, n_hold); else passed++;
    init_calib_complete = 1'b1;
    wait_done(1000, ok);
    bad_a = 0;
    for (int k = 0; k < wcmd_addr.size(); k++) if (wcmd_addr[k] !== seq_addr(k)) bad_a++;
    checks++; if (!ok || wcmd_addr.size() != REGION_BEATS || bad_a != 0)
      $display("FAIL calib_resume: got done=%0d beats=%0d bad=%0d expected 1/%0d/0", ok, wcmd_addr.size(), bad_a, REGION_BEATS); else passed++;
  endtask

  task automatic test_read(input bit rnd, input bit rand_rdy, input int ca, input int cb);
    bit ok;
    int n, bad_a, exp_err;
    logic [15:0] l;
    logic [ADDR_W-1:0] exp_addr[$];
    n = rnd ? RAND_BEATS : REGION_BEATS;
    l = 16'hACE1;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(rnd ? ADDR_W'(BASE_ADDR + int'(l & 16'h007F) * ADDR_STEP) : seq_addr(k));
      l = {l[14:0], ^(l & 16'hB400)};
    end
    exp_err = 0;
`ifdef DDR_TEST_CMP_EN
    if (ca >= 0 && ca < n) exp_err++;
    if (cb >= 0 && cb < n && cb != ca) exp_err++;
`endif
    rq.delete();
    clear_logs();
    rdy_rand = rand_rdy;
    corrupt_a = ca;
    corrupt_b = cb;
    reads_active = 1;
    send_cmd(rnd ? 8'h03 : 8'h02);
    wait_done(6000, ok);
    reads_active = 0;
    bad_a = 0;
    for (int k = 0; k < rcmd_addr.size() && k < n; k++) if (rcmd_addr[k] !== exp_addr[k]) bad_a++;
    checks++; if (!ok) $display("FAIL rd_done: got no done expected done pulse"); else passed++;
    checks++; if (rcmd_addr.size() != n) $display("FAIL rd_issued: got %0d expected %0d", rcmd_addr.size(), n); else passed++;
    checks++; if (bad_a != 0) $display("FAIL rd_addr: got %0d wrong addresses expected 0", bad_a); else passed++;
    checks++; if (rets != n) $display("FAIL rd_returns: got %0d expected %0d", rets, n); else passed++;
    checks++; if (max_outst > MAX_OUTST) $display("FAIL rd_outst_limit: got %0d expected <= %0d", max_outst, MAX_OUTST); else passed++;
    checks++; if (err_cnt !== ERR_W'(exp_err)) $display("FAIL rd_err_cnt: got %0d expected %0d", err_cnt, exp_err); else passed++;
    checks++; if (state !== 2'd0 || done_bad != 0) $display("FAIL rd_end: got state=%0d done_bad=%0d expected 0/0", state, done_bad); else passed++;
    if (!rand_rdy) begin
      checks++; if (max_outst != MAX_OUTST) $display("FAIL rd_outst_peak: got %0d expected %0d", max_outst, MAX_OUTST); else passed++;
    end
    if (rnd && rcmd_addr.size() > 0) begin
      checks++; if (rcmd_addr[0] !== ADDR_W'(28'h308)) $display("FAIL rnd_first_addr: got %0h expected 308", rcmd_addr[0]); else passed++;
    end
    corrupt_a = -1;
    corrupt_b = -1;
    rdy_rand = 0;
  endtask

  task automatic test_reset_mid();
    int start;
    rq.delete();
    clear_logs();
    corrupt_all = 1;
    start = done_cnt;
    send_cmd(8'h02);
    tick(30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(45);
    checks++; if (state !== 2'd0 || app_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_idle: got state=%0d en=%b busy=%b expected 0/0/0", state, app_en, busy); else passed++;
    checks++; if (done_cnt != start) $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - start); else passed++;
    checks++; if (err_cnt !== '0) $display("FAIL abort_err: got %0d expected 0", err_cnt); else passed++;
    send_cmd(8'h55);
    tick(5);
    checks++; if (state !== 2'd0 || app_en !== 1'b0) $display("FAIL bad_cmd_ignored: got state=%0d en=%b expected 0/0", state, app_en); else passed++;
    corrupt_all = 0;
    rq.delete();
  endtask

  initial begin
    tick(1);
    test_reset();
    test_write(0, -1);
    test_write(0, 5);
    test_write(1, -1);
    test_calib();
    test_read(0, 0, -1, -1);
    test_read(0, 0, 3, 7);
    test_read(1, 1, $urandom_range(0, RAND_BEATS - 1), $urandom_range(0, RAND_BEATS - 1));
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
